// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioner slice.
// Holds the debouncer state encoding, the switch count, and the default
// debounce length for a 50 MHz clock.
package input_cond_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } db_state_t;

    localparam int unsigned NUM_SW                  = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;  // 1 ms at 50 MHz

endpackage

// File: rtl/debounce_ch.sv
// One debounced input channel: synchroniser chain, two-state debounce FSM,
// qualification counter and registered output level.
//
// Ports:
//   clk      rising-edge system clock
//   rst_n    asynchronous active-low reset
//   raw      asynchronous input pin
//   db_out   debounced level, resets to RST_VAL
module debounce_ch
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_in;
    db_state_t              state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_in = sync[SYNC_STAGES-1];

    // The output resets to the same level as the synchroniser so that a
    // released input does not trigger a qualification run after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_STABLE;
            cnt    <= '0;
            db_out <= RST_VAL;
        end else begin
            unique case (state)
                ST_STABLE: begin
                    if (sync_in != db_out) begin
                        state <= ST_CHECK;
                        cnt   <= '0;
                    end
                end
                ST_CHECK: begin
                    if (sync_in == db_out) begin
                        state <= ST_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        db_out <= sync_in;
                        state  <= ST_STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_STABLE;
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end feeding dmux: synchronises and debounces the push
// button and the switch bank, normalises button polarity to active-high and
// produces one-cycle press / switch-change strobes.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   pba_raw    raw push-button pin
//   sw_raw     raw slide-switch pins
//   pba        debounced button level, 1 = pressed
//   pba_press  one-cycle strobe after pba rises
//   sw         debounced switch levels
//   sw_chg     one-cycle strobe after any sw bit commits
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pba_raw,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic              pba,
    output logic              pba_press,
    output logic [NUM_SW-1:0] sw,
    output logic              sw_chg
);

    localparam logic BTN_REL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic              btn_db;
    logic              pba_d;
    logic [NUM_SW-1:0] sw_d;

    // The button channel debounces the pin-level signal and inversion is
    // applied on its output; this is equivalent to inverting before the
    // FSM because the FSM is symmetric and its reset level tracks the
    // released pin level.
    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .SYNC_STAGES     (SYNC_STAGES),
        .RST_VAL         (BTN_REL)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (pba_raw),
        .db_out (btn_db)
    );

    assign pba = BTN_ACTIVE_LOW ? ~btn_db : btn_db;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES),
            .RST_VAL         (1'b0)
        ) u_sw (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (sw_raw[i]),
            .db_out (sw[i])
        );
    end

    // Strobes compare against last cycle's levels, so they land one cycle
    // after the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pba_d     <= 1'b0;
            sw_d      <= '0;
            pba_press <= 1'b0;
            sw_chg    <= 1'b0;
        end else begin
            pba_d     <= pba;
            sw_d      <= sw;
            pba_press <= pba & ~pba_d;
            sw_chg    <= |(sw ^ sw_d);
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned CW = 3;
    localparam int unsigned LAT = SS + DB + 1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       pba_raw = 1'b1;
    logic [3:0] sw_raw  = 4'b0000;
    logic       pba;
    logic       pba_press;
    logic [3:0] sw;
    logic       sw_chg;

    int total = 0;
    int bad   = 0;
    int n_press = 0;
    int n_chg   = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW),
        .SYNC_STAGES     (SS),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pba_raw   (pba_raw),
        .sw_raw    (sw_raw),
        .pba       (pba),
        .pba_press (pba_press),
        .sw        (sw),
        .sw_chg    (sw_chg)
    );

    // Reference model. Channel 0 is the button (active-high), 1..4 are
    // switches. Each input is seen SS edges late; a level is accepted once
    // it has disagreed with the output on DB+1 consecutive samples.
    bit m_q[5][$];
    int m_run[5];
    bit m_out[5];
    bit rose_last, commit_last;
    bit e_press, e_chg;

    function automatic void model_reset();
        for (int c = 0; c < 5; c++) begin
            m_q[c].delete();
            for (int k = 0; k < int'(SS); k++) m_q[c].push_back(1'b0);
            m_run[c] = 0;
            m_out[c] = 1'b0;
        end
        rose_last = 0; commit_last = 0; e_press = 0; e_chg = 0;
    endfunction

    function automatic void model_edge();
        bit in_v[5];
        bit s;
        bit rose, commit;
        in_v[0] = ~pba_raw;
        for (int i = 0; i < 4; i++) in_v[i+1] = sw_raw[i];
        e_press = rose_last;
        e_chg   = commit_last;
        rose = 0; commit = 0;
        for (int c = 0; c < 5; c++) begin
            s = m_q[c].pop_front();
            if (s != m_out[c]) begin
                m_run[c]++;
                if (m_run[c] == int'(DB) + 1) begin
                    m_out[c] = s;
                    m_run[c] = 0;
                    if (c == 0 && s) rose = 1;
                    if (c != 0) commit = 1;
                end
            end else begin
                m_run[c] = 0;
            end
            m_q[c].push_back(in_v[c]);
        end
        rose_last = rose;
        commit_last = commit;
    endfunction

    function automatic void check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endfunction

    function automatic void check_all(input string tag);
        logic [3:0] esw;
        for (int i = 0; i < 4; i++) esw[i] = m_out[i+1];
        check({tag, ".pba"}, 32'(pba), 32'(m_out[0]));
        check({tag, ".pba_press"}, 32'(pba_press), 32'(e_press));
        check({tag, ".sw"}, 32'(sw), 32'(esw));
        check({tag, ".sw_chg"}, 32'(sw_chg), 32'(e_chg));
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        if (pba_press === 1'b1) n_press++;
        if (sw_chg === 1'b1) n_chg++;
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic apply_reset(input int n, input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        check({tag, ".async_pba"}, 32'(pba), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_all({tag, ".hold"});
        end
        rst_n = 1'b1;
    endtask

    task automatic measure_pba(input logic lvl, input string tag);
        int n = 0;
        while (pba !== lvl && n < 40) begin
            tick(tag);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(LAT));
    endtask

    task automatic measure_sw(input logic [3:0] exp_sw, input string tag);
        logic [3:0] start;
        int n = 0;
        start = sw;
        while (sw === start && n < 40) begin
            tick(tag);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(LAT));
        check({tag, ".value"}, 32'(sw), 32'(exp_sw));
    endtask

    initial begin
        int p0, c0, hi;
        bit seen;

        #2;
        // 1: reset with pins active, then release
        pba_raw = 1'b1;
        sw_raw  = 4'b1010;
        apply_reset(3, "rst");
        c0 = n_chg;
        measure_sw(4'b1010, "rst_sw");
        tick("rst_chg");
        check("rst_chg_hi", 32'(sw_chg), 32'd1);
        tick("rst_chg2");
        check("rst_chg_once", 32'(n_chg - c0), 32'd1);

        // 2: clean press, hold, release
        sw_raw = 4'b0000;
        ticks(10, "settle");
        p0 = n_press;
        pba_raw = 1'b0;
        measure_pba(1'b1, "press");
        tick("press_strobe");
        check("press_strobe_hi", 32'(pba_press), 32'd1);
        ticks(12, "hold");
        check("press_once", 32'(n_press - p0), 32'd1);
        pba_raw = 1'b1;
        measure_pba(1'b0, "release");
        ticks(5, "release_after");
        check("release_no_strobe", 32'(n_press - p0), 32'd1);

        // 3: bouncing press
        p0 = n_press;
        hi = 0;
        for (int b = 0; b < 4; b++) begin
            pba_raw = (b % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 2; k++) begin
                tick("bounce");
                if (pba === 1'b1) hi++;
            end
        end
        check("bounce_quiet", 32'(hi), 32'd0);
        pba_raw = 1'b0;
        measure_pba(1'b1, "bounce_final");
        ticks(4, "bounce_after");
        check("bounce_one_press", 32'(n_press - p0), 32'd1);
        pba_raw = 1'b1;
        ticks(12, "bounce_release");

        // 4: short glitch rejected, DB+1 sample pulse accepted
        c0 = n_chg;
        sw_raw = 4'b0100;
        ticks(3, "glitch");
        sw_raw = 4'b0000;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick("glitch_after");
            if (sw !== 4'b0000) hi++;
        end
        check("glitch_sw", 32'(hi), 32'd0);
        check("glitch_chg", 32'(n_chg - c0), 32'd0);
        sw_raw = 4'b0100;
        ticks(int'(DB) + 1, "pulse");
        sw_raw = 4'b0000;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick("pulse_after");
            if (sw === 4'b0100) seen = 1;
        end
        check("pulse_sw2_seen", 32'(seen), 32'd1);
        check("pulse_chg", 32'(n_chg - c0), 32'd2);

        // 5: all switches change together
        c0 = n_chg;
        sw_raw = 4'b1111;
        measure_sw(4'b1111, "simul");
        ticks(3, "simul_after");
        check("simul_one_chg", 32'(n_chg - c0), 32'd1);

        // 6: reset during qualification
        pba_raw = 1'b0;
        ticks(3, "midchk");
        apply_reset(2, "midrst");
        measure_pba(1'b1, "midrst_press");
        pba_raw = 1'b1;
        ticks(12, "midrst_rel");

        // random stimulus against the model
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            pba_raw = 1'($urandom);
            if ($urandom_range(0, 1) == 0) sw_raw = 4'($urandom);
            len = int'($urandom_range(1, 8));
            ticks(len, "rand");
        end
        ticks(15, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
